mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter and sequencer for the single `memory0` port. It sits between the `cpu0` core (master 0) and a second bus master (master 1, DMA/IO engine) and time-shares the one memory port between them. It registers each accepted request, drives the `en/rw/m_size/abus/dbus_in` side of `memory0` for exactly one access cycle, captures `dbus_out`, and returns a one-cycle acknowledge. Round-robin arbitration prevents starvation.

## Interface
- `MEMSIZE`, default `'h80000`: memory size in bytes. An access is legal iff `addr <= MEMSIZE-4`.
- `clock`, input, 1: the single clock; all state updates on posedge.
- `reset`, input, 1: synchronous, active-low; sampled on posedge clock.
- `req0` / `req1`, input, 1: access request from master 0 / master 1.
- `rw0` / `rw1`, input, 1: 1 = read, 0 = write.
- `size0` / `size1`, input, 2: `2'b00` BYTE, `2'b01` INT16, `2'b10` INT24, `2'b11` INT32.
- `addr0` / `addr1`, input, 32: byte address.
- `wdata0` / `wdata1`, input, 32: write data, right-aligned.
- `ack0` / `ack1`, output, 1: one-cycle completion pulse to the owning master.
- `err0` / `err1`, output, 1: valid with ack; 1 = address out of range, no memory access made.
- `rdata`, output, 32: read data, shared by both masters; valid in the ack cycle.
- `gnt`, output, 2: one-hot current owner; `2'b00` when idle.
- `m_en`, output, 1: memory enable, to `memory0.en`.
- `m_rw`, output, 1: to `memory0.rw`.
- `m_size`, output, 2: to `memory0.m_size`.
- `mar`, output, 32: to `memory0.abus`.
- `mdr`, output, 32: to `memory0.dbus_in`.
- `dbus`, input, 32: from `memory0.dbus_out`.

## Operation
- FSM states:
  - IDLE: at posedge, if any `req` is high, select a winner, latch its `rw/size/addr/wdata`, set `gnt`, and go to ACCESS.
  - ACCESS: registered outputs drive the memory for this whole cycle. For a legal address, `m_en=1`, `m_rw=rw`, `m_size=size`, `mar=addr`, and `mdr=wdata` for writes. For an illegal address, `m_en` stays 0. At the closing posedge, reads latch `rdata<=dbus`; writes and errors latch `rdata<=0`. Go to DONE.
  - DONE: `m_en=0`, `ack` of the owner is 1, and `err` of the owner reflects the range check. At the closing posedge, clear `gnt` and `ack` and go to IDLE.
- Arbitration uses a 1-bit `last` pointer.
  - Only one request high: that master wins.
  - Both high: the master that is not `last` wins.
  - `last` updates to the winner on each grant.
- `req` is sampled only in IDLE. It is ignored in ACCESS and DONE.
- Masters hold `req/rw/size/addr/wdata` stable until they see ack, then deassert `req` in the next cycle (a registered response).
- `m_rw`, `m_size` and `mar` retain their last values when `m_en=0`. `mdr` updates only on writes.
- Width rules:
  - `rdata` passes `dbus` unmodified; `memory0` already zero-extends BYTE/INT16/INT24.
  - Sign extension belongs to the requester.
  - Range check is unsigned: `addr <= MEMSIZE-4`. `'h7FFFC` is legal; `'h7FFFD` and `'h80000` (IOADDR) are errors.

## Timing
- Reset values (at the first posedge with `reset=0`):
  - state IDLE, `last=1` (so master 0 wins first tie), `gnt=0`.
  - `m_en=0`, `m_rw=1`, `m_size=2'b11`, `mar=0`, `mdr=0`.
  - `rdata=0`, `ack0=ack1=0`, `err0=err1=0`.
- Latency: `req` sampled in cycle N, memory driven in N+1, ack in N+2. Earliest next grant is sampled in N+3.
- Throughput: at most one access per 3 cycles.
- `ack` is high for exactly one cycle per accepted request, and only for the granted master.
- Reset mid-operation (ACCESS or DONE): return to IDLE with all reset values. The pending access is abandoned with no ack. A write in progress may or may not have reached memory.
- Simultaneous requests: both high in IDLE means exactly one is granted. The loser stays pending and is granted in the next IDLE.
- `m_en` is never high in two consecutive cycles.

## Test plan
- Single read: preload `m['h100..'h103]=DE AD BE EF`. Assert `req0`, `rw0=1`, `size0=INT32`, `addr0='h100`. Expect `m_en=1` and `mar='h100` in N+1, then `ack0=1`, `err0=0`, `rdata='hDEADBEEF` in N+2.
- Single write then read: master 1 writes BYTE `'h41` to `'h200`; expect `ack1` in N+2 and `m['h200]='h41`. Master 1 then reads BYTE at `'h200`; expect `rdata='h00000041`.
- Simultaneous requests after reset: both `req` high. Expect `gnt=01` and `ack0` first, then `gnt=10` and `ack1` three cycles later. Repeat the tie and expect master 0 first again (`last=1`).
- Fairness: hold `req0` and `req1` continuously for 6 accesses. Expect grants in the strict order 0,1,0,1,0,1.
- Out-of-range: `req0`, read, `addr0='h80000`. Expect `m_en=0` throughout, `ack0=1`, `err0=1`, `rdata=0` in N+2. Repeat with `'h7FFFC` and expect `err0=0`.
- Reset mid-access: assert `reset=0` during ACCESS. Expect no `ack`, `gnt=0`, `m_en=0` after the edge. With `req0` still high, expect a full new 3-cycle access after reset releases.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter and sequencer for memory0.
// Each accepted request takes three cycles: grant (IDLE), one memory access
// cycle (ACCESS), and a one-cycle acknowledge to the owner (DONE).
module mem_arbiter #(
  parameter logic [31:0] MEMSIZE = 32'h80000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        rw0,
  input  logic [1:0]  size0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic        rw1,
  input  logic [1:0]  size1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic [1:0]  gnt,
  output logic        m_en,
  output logic        m_rw,
  output logic [1:0]  m_size,
  output logic [31:0] mar,
  output logic [31:0] mdr,
  input  logic [31:0] dbus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  // Highest legal start address; the check is unsigned.
  localparam logic [31:0] MAX_ADDR = MEMSIZE - 32'd4;

  logic [1:0]  state;
  logic        last;
  logic        owner;
  logic        lat_rw;
  logic        lat_err;

  logic        win;
  logic        w_rw;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_legal;

  // Round-robin winner selection and the winner's request fields.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = ~last;
    end else if (req1) begin
      win = 1'b1;
    end
    w_rw    = win ? rw1    : rw0;
    w_size  = win ? size1  : size0;
    w_addr  = win ? addr1  : addr0;
    w_wdata = win ? wdata1 : wdata0;
    w_legal = (w_addr <= MAX_ADDR);
  end

  // Sequencer: grant, drive memory for one cycle, then acknowledge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      last    <= 1'b1;
      owner   <= 1'b0;
      lat_rw  <= 1'b1;
      lat_err <= 1'b0;
      gnt     <= '0;
      m_en    <= 1'b0;
      m_rw    <= 1'b1;
      m_size  <= 2'b11;
      mar     <= '0;
      mdr     <= '0;
      rdata   <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner   <= win;
            last    <= win;
            gnt     <= win ? 2'b10 : 2'b01;
            lat_rw  <= w_rw;
            lat_err <= ~w_legal;
            // Memory-side registers are loaded here so they are valid for
            // the whole ACCESS cycle; an illegal address leaves them untouched.
            m_en    <= w_legal;
            if (w_legal) begin
              m_rw   <= w_rw;
              m_size <= w_size;
              mar    <= w_addr;
              if (!w_rw) begin
                mdr <= w_wdata;
              end
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          m_en  <= 1'b0;
          rdata <= (lat_rw && !lat_err) ? dbus : '0;
          ack0  <= ~owner;
          ack1  <= owner;
          err0  <= ~owner & lat_err;
          err1  <= owner & lat_err;
          state <= DONE;
        end
        DONE: begin
          gnt   <= '0;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err0  <= 1'b0;
          err1  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural big-endian memory0.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, rw0 = 1'b1, req1 = 1'b0, rw1 = 1'b1;
  logic [1:0]  size0 = 2'b11, size1 = 2'b11;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata;
  logic [1:0]  gnt;
  logic        m_en, m_rw;
  logic [1:0]  m_size;
  logic [31:0] mar, mdr;
  logic [31:0] dbus;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        m;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t expq[$];

  logic [7:0] mem [0:32'h7FFFF];
  logic [18:0] ma;
  logic m_en_prev = 1'b0;

  mem_arbiter #(.MEMSIZE(32'h80000)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .rw0(rw0), .size0(size0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .rw1(rw1), .size1(size1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata(rdata), .gnt(gnt),
    .m_en(m_en), .m_rw(m_rw), .m_size(m_size), .mar(mar), .mdr(mdr),
    .dbus(dbus)
  );

  always #5 clock = ~clock;

  // memory0 model: combinational zero-extended read, write on posedge.
  assign ma = mar[18:0];
  always_comb begin
    dbus = '0;
    if (m_en && m_rw) begin
      case (m_size)
        2'b00: dbus = {24'h0, mem[ma]};
        2'b01: dbus = {16'h0, mem[ma], mem[ma+19'd1]};
        2'b10: dbus = {8'h0, mem[ma], mem[ma+19'd1], mem[ma+19'd2]};
        default: dbus = {mem[ma], mem[ma+19'd1], mem[ma+19'd2], mem[ma+19'd3]};
      endcase
    end
  end

  always @(posedge clock) begin
    if (m_en && !m_rw) begin
      case (m_size)
        2'b00: mem[ma] <= mdr[7:0];
        2'b01: begin mem[ma] <= mdr[15:8]; mem[ma+19'd1] <= mdr[7:0]; end
        2'b10: begin
          mem[ma] <= mdr[23:16]; mem[ma+19'd1] <= mdr[15:8]; mem[ma+19'd2] <= mdr[7:0];
        end
        default: begin
          mem[ma] <= mdr[31:24]; mem[ma+19'd1] <= mdr[23:16];
          mem[ma+19'd2] <= mdr[15:8]; mem[ma+19'd3] <= mdr[7:0];
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ack(input logic m, input logic err, input logic [31:0] rd);
    exp_t e;
    e.m = m; e.err = err; e.rdata = rd;
    expq.push_back(e);
  endtask

  task automatic set_master(input logic m, input logic rq, input logic rw,
                            input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd);
    if (m) begin
      req1 = rq; rw1 = rw; size1 = sz; addr1 = ad; wdata1 = wd;
    end else begin
      req0 = rq; rw0 = rw; size0 = sz; addr0 = ad; wdata0 = wd;
    end
  endtask

  // Master behaviour: hold the request until ack, drop it the next cycle.
  task automatic run_req(input logic m, input logic rw, input logic [1:0] sz,
                         input logic [31:0] ad, input logic [31:0] wd);
    bit seen;
    int unsigned n;
    seen = 0;
    n = 0;
    set_master(m, 1'b1, rw, sz, ad, wd);
    while (!seen && n < 20) begin
      @(negedge clock);
      if (m ? ack1 : ack0) seen = 1;
      n++;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ack_timeout: master %0d got no ack expected ack within 20 cycles", m);
    end
    @(posedge clock);
    #1;
    set_master(m, 1'b0, rw, sz, ad, wd);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clock) begin
    exp_t e;
    if (m_en) chk("m_en_back_to_back", {31'h0, m_en_prev}, 32'h0);
    m_en_prev <= m_en;
    if (ack0 || ack1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=%b%b expected none", ack1, ack0);
      end else begin
        e = expq.pop_front();
        chk("ack_owner", {30'h0, ack1, ack0}, e.m ? 32'h2 : 32'h1);
        chk("gnt", {30'h0, gnt}, e.m ? 32'h2 : 32'h1);
        chk("err", {30'h0, err1, err0}, !e.err ? 32'h0 : (e.m ? 32'h2 : 32'h1));
        chk("rdata", rdata, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mem['h100] = 8'hDE; mem['h101] = 8'hAD; mem['h102] = 8'hBE; mem['h103] = 8'hEF;
    mem['h7FFFC] = 8'h11; mem['h7FFFD] = 8'h22; mem['h7FFFE] = 8'h33; mem['h7FFFF] = 8'h44;

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_gnt", {30'h0, gnt}, 32'h0);
    chk("rst_m_en", {31'h0, m_en}, 32'h0);
    chk("rst_m_rw", {31'h0, m_rw}, 32'h1);
    chk("rst_m_size", {30'h0, m_size}, 32'h3);
    chk("rst_mar", mar, 32'h0);
    chk("rst_mdr", mdr, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ack_err", {28'h0, ack1, ack0, err1, err0}, 32'h0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Tie after reset: master 0 first, then master 1; twice.
    repeat (2) begin
      expect_ack(1'b0, 1'b0, 32'hDEADBEEF);
      expect_ack(1'b1, 1'b0, 32'h0000BEEF);
      fork
        run_req(1'b0, 1'b1, 2'b11, 32'h100, 32'h0);
        run_req(1'b1, 1'b1, 2'b01, 32'h102, 32'h0);
      join
    end

    // Fairness: both masters continuously requesting, strict alternation.
    repeat (3) begin
      expect_ack(1'b0, 1'b0, 32'hDEADBEEF);
      expect_ack(1'b1, 1'b0, 32'h00ADBEEF);
    end
    fork
      repeat (3) run_req(1'b0, 1'b1, 2'b11, 32'h100, 32'h0);
      repeat (3) run_req(1'b1, 1'b1, 2'b10, 32'h101, 32'h0);
    join

    // Single read with latency checks on the memory side.
    expect_ack(1'b0, 1'b0, 32'hDEADBEEF);
    fork
      run_req(1'b0, 1'b1, 2'b11, 32'h100, 32'h0);
      begin
        @(negedge clock);
        @(negedge clock);
        chk("read_m_en", {31'h0, m_en}, 32'h1);
        chk("read_mar", mar, 32'h100);
        chk("read_m_rw", {31'h0, m_rw}, 32'h1);
      end
    join

    // Master 1 byte write then byte read.
    expect_ack(1'b1, 1'b0, 32'h0);
    run_req(1'b1, 1'b0, 2'b00, 32'h200, 32'h41);
    chk("write_mem", {24'h0, mem['h200]}, 32'h41);
    chk("write_mdr", mdr, 32'h41);
    expect_ack(1'b1, 1'b0, 32'h00000041);
    run_req(1'b1, 1'b1, 2'b00, 32'h200, 32'h0);

    // Out-of-range: no memory enable, error with zero data.
    expect_ack(1'b0, 1'b1, 32'h0);
    fork
      run_req(1'b0, 1'b1, 2'b11, 32'h80000, 32'h0);
      begin
        @(negedge clock);
        @(negedge clock);
        chk("oor_m_en_access", {31'h0, m_en}, 32'h0);
        @(negedge clock);
        chk("oor_m_en_done", {31'h0, m_en}, 32'h0);
      end
    join
    expect_ack(1'b0, 1'b1, 32'h0);
    run_req(1'b0, 1'b1, 2'b11, 32'h7FFFD, 32'h0);
    expect_ack(1'b0, 1'b0, 32'h11223344);
    run_req(1'b0, 1'b1, 2'b11, 32'h7FFFC, 32'h0);

    // Reset during ACCESS: abandoned, then a fresh access after release.
    set_master(1'b0, 1'b1, 1'b1, 2'b11, 32'h100, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rstmid_access_en", {31'h0, m_en}, 32'h1);
    @(negedge clock);
    chk("rstmid_ack", {30'h0, ack1, ack0}, 32'h0);
    chk("rstmid_gnt", {30'h0, gnt}, 32'h0);
    chk("rstmid_m_en", {31'h0, m_en}, 32'h0);
    reset = 1'b1;
    expect_ack(1'b0, 1'b0, 32'hDEADBEEF);
    run_req(1'b0, 1'b1, 2'b11, 32'h100, 32'h0);

    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("scoreboard_empty", expq.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
